// File: rtl/hctrl_pkg.sv
// Shared definitions for the hand-controller port block: button bit positions,
// NMI sequencer state encoding and the opposing-direction resolver.
package hctrl_pkg;

    localparam int HC_UP    = 0;
    localparam int HC_DOWN  = 1;
    localparam int HC_LEFT  = 2;
    localparam int HC_RIGHT = 3;
    localparam int HC_TL    = 4;
    localparam int HC_TR    = 5;
    localparam int HC_PAUSE = 6;

    typedef enum logic [1:0] {
        NMI_IDLE     = 2'd0,
        NMI_PULSE    = 2'd1,
        NMI_WAIT_REL = 2'd2
    } nmi_state_e;

    // Active-low byte: a pad reporting both opposing directions reports neither.
    function automatic logic [7:0] resolve_opposing(input logic [7:0] b);
        logic [7:0] r;
        logic       ud_both;
        logic       lr_both;
        ud_both     = ~b[HC_UP] & ~b[HC_DOWN];
        lr_both     = ~b[HC_LEFT] & ~b[HC_RIGHT];
        r           = b;
        r[HC_UP]    = b[HC_UP] | ud_both;
        r[HC_DOWN]  = b[HC_DOWN] | ud_both;
        r[HC_LEFT]  = b[HC_LEFT] | lr_both;
        r[HC_RIGHT] = b[HC_RIGHT] | lr_both;
        return r;
    endfunction

endpackage

// File: rtl/hctrl_debounce.sv
// 8-bit tick-sampled debouncer: a new value is accepted only after it has been
// seen on STABLE_SAMPLES consecutive ticks.
module hctrl_debounce
    import hctrl_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_i,
    input  logic [7:0] data_i,
    output logic [7:0] stable_o
);

    localparam logic [3:0] SAMPLES = 4'(STABLE_SAMPLES);

    logic [7:0] cand_q;
    logic [7:0] cand_d;
    logic [7:0] stable_q;
    logic [7:0] stable_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Candidate tracking; the count saturates at SAMPLES once accepted.
    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick_i) begin
            if (data_i != cand_q) begin
                cand_d = data_i;
                cnt_d  = 4'd1;
            end else if (cnt_q < SAMPLES) begin
                cnt_d = cnt_q + 4'd1;
                if ((cnt_q + 4'd1) == SAMPLES) begin
                    stable_d = cand_q;
                end else begin
                    stable_d = stable_q;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q   <= 8'hFF;
            stable_q <= 8'hFF;
            cnt_q    <= 4'd0;
        end else begin
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/hctrl_ports.sv
// Debounced controller bytes mapped onto joypad ports $DC/$DD, plus a
// one-shot fixed-width NMI pulse per pause press.
module hctrl_ports
    import hctrl_pkg::*;
#(
    parameter int TICK_DIV       = 4096,
    parameter int STABLE_SAMPLES = 4,
    parameter int NMI_WIDTH      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hctrl1_data,
    input  logic [7:0] hctrl2_data,
    input  logic       th_a,
    input  logic       th_b,
    output logic [7:0] port_dc,
    output logic [7:0] port_dd,
    output logic       nmi_n
);

    localparam int TCW = $clog2(TICK_DIV);
    localparam int NCW = (NMI_WIDTH > 1) ? $clog2(NMI_WIDTH) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [NCW-1:0] NMI_LAST  = NCW'(NMI_WIDTH - 1);

    logic [TCW-1:0] tcnt_q;
    logic           tick_s;
    logic [7:0]     s1_s;
    logic [7:0]     s2_s;
    logic [7:0]     r1_s;
    logic [7:0]     r2_s;
    logic [7:0]     port_dc_d;
    logic [7:0]     port_dd_d;
    logic [7:0]     port_dc_q;
    logic [7:0]     port_dd_q;
    logic           pause_n_s;
    nmi_state_e     state_q;
    nmi_state_e     state_d;
    logic [NCW-1:0] ncnt_q;
    logic [NCW-1:0] ncnt_d;
    logic           nmi_n_q;
    logic           nmi_n_d;

    assign tick_s = (tcnt_q == TICK_LAST);

    // Free-running sample-tick divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
        end else if (tick_s) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + {{(TCW-1){1'b0}}, 1'b1};
        end
    end

    hctrl_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_deb1 (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (tick_s),
        .data_i   (hctrl1_data),
        .stable_o (s1_s)
    );

    hctrl_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_deb2 (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (tick_s),
        .data_i   (hctrl2_data),
        .stable_o (s2_s)
    );

    assign r1_s      = resolve_opposing(s1_s);
    assign r2_s      = resolve_opposing(s2_s);
    assign pause_n_s = s1_s[HC_PAUSE] & s2_s[HC_PAUSE];

    // Port bit packing; bits 5:4 of $DD are CONT and the absent RESET button.
    always_comb begin
        port_dc_d = {r2_s[HC_DOWN], r2_s[HC_UP], r1_s[HC_TR], r1_s[HC_TL],
                     r1_s[HC_RIGHT], r1_s[HC_LEFT], r1_s[HC_DOWN], r1_s[HC_UP]};
        port_dd_d = {th_b, th_a, 1'b1, 1'b1,
                     r2_s[HC_TR], r2_s[HC_TL], r2_s[HC_RIGHT], r2_s[HC_LEFT]};
    end

    // Registered port read values.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_dc_q <= 8'hFF;
            port_dd_q <= 8'hFF;
        end else begin
            port_dc_q <= port_dc_d;
            port_dd_q <= port_dd_d;
        end
    end

    // NMI sequencer state, pulse counter and registered nmi_n.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NMI_IDLE;
            ncnt_q  <= '0;
            nmi_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ncnt_q  <= ncnt_d;
            nmi_n_q <= nmi_n_d;
        end
    end

    // NMI next-state: one pulse per press, then wait for release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NMI_IDLE: begin
                if (!pause_n_s) begin
                    state_d = NMI_PULSE;
                end else begin
                    state_d = NMI_IDLE;
                end
            end
            NMI_PULSE: begin
                if (ncnt_q == '0) begin
                    state_d = NMI_WAIT_REL;
                end else begin
                    state_d = NMI_PULSE;
                end
            end
            NMI_WAIT_REL: begin
                if (pause_n_s) begin
                    state_d = NMI_IDLE;
                end else begin
                    state_d = NMI_WAIT_REL;
                end
            end
            default: state_d = NMI_IDLE;
        endcase
    end

    // NMI outputs: nmi_n falls on entry to PULSE and rises after NMI_WIDTH clks.
    always_comb begin
        ncnt_d  = ncnt_q;
        nmi_n_d = nmi_n_q;
        case (state_q)
            NMI_IDLE: begin
                if (!pause_n_s) begin
                    nmi_n_d = 1'b0;
                    ncnt_d  = NMI_LAST;
                end else begin
                    nmi_n_d = 1'b1;
                end
            end
            NMI_PULSE: begin
                if (ncnt_q == '0) begin
                    nmi_n_d = 1'b1;
                end else begin
                    ncnt_d = ncnt_q - {{(NCW-1){1'b0}}, 1'b1};
                end
            end
            NMI_WAIT_REL: nmi_n_d = 1'b1;
            default:      nmi_n_d = 1'b1;
        endcase
    end

    assign port_dc = port_dc_q;
    assign port_dd = port_dd_q;
    assign nmi_n   = nmi_n_q;

endmodule

// File: tb/tb_hctrl_ports.sv
// Randomized and directed bench for hctrl_ports, checked every clock against
// a sample-history reference model.
module tb_hctrl_ports;

    localparam int TD = 4;
    localparam int SS = 3;
    localparam int NW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] h1;
    logic [7:0] h2;
    logic       tha;
    logic       thb;
    logic [7:0] pdc;
    logic [7:0] pdd;
    logic       nmi;

    always #5 clk = ~clk;

    hctrl_ports #(.TICK_DIV(TD), .STABLE_SAMPLES(SS), .NMI_WIDTH(NW)) dut (
        .clk         (clk),
        .reset       (reset),
        .hctrl1_data (h1),
        .hctrl2_data (h2),
        .th_a        (tha),
        .th_b        (thb),
        .port_dc     (pdc),
        .port_dd     (pdd),
        .nmi_n       (nmi)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int         edge_no   = 0;
    int         phase     = 0;
    logic [7:0] last1, last2, st1, st2;
    int         run1, run2;
    logic [7:0] e_dc, e_dd;
    logic       e_nmi;
    bit         armed;
    bit         pulsed;
    int         pstart;
    int         low_len   = 0;

    function automatic logic [7:0] unopposed(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b[0] == 1'b0 && b[1] == 1'b0) begin r[0] = 1'b1; r[1] = 1'b1; end
        if (b[2] == 1'b0 && b[3] == 1'b0) begin r[2] = 1'b1; r[3] = 1'b1; end
        return r;
    endfunction

    task automatic model_edge();
        logic [7:0] f1, f2;
        bit pressed;
        if (reset) begin
            phase = 0; last1 = 8'hFF; last2 = 8'hFF; st1 = 8'hFF; st2 = 8'hFF;
            run1 = 0; run2 = 0; e_dc = 8'hFF; e_dd = 8'hFF; e_nmi = 1'b1;
            armed = 1'b1; pulsed = 1'b0;
        end else begin
            f1 = unopposed(st1);
            f2 = unopposed(st2);
            e_dc = {f2[1], f2[0], f1[5], f1[4], f1[3], f1[2], f1[1], f1[0]};
            e_dd = {thb, tha, 1'b1, 1'b1, f2[5], f2[4], f2[3], f2[2]};
            pressed = (st1[6] == 1'b0) || (st2[6] == 1'b0);
            if (armed && pressed) begin
                armed = 1'b0; pulsed = 1'b1; pstart = edge_no;
            end else if (!armed && edge_no > pstart + NW && !pressed) begin
                armed = 1'b1;
            end
            e_nmi = !(pulsed && edge_no >= pstart && edge_no < pstart + NW);
            if (phase == TD - 1) begin
                phase = 0;
                if (h1 == last1) run1++; else begin last1 = h1; run1 = 1; end
                if (h2 == last2) run2++; else begin last2 = h2; run2 = 1; end
                if (run1 >= SS) st1 = last1;
                if (run2 >= SS) st2 = last2;
            end else begin
                phase++;
            end
        end
        edge_no++;
    endtask

    task automatic cycle();
        bit was_reset;
        @(posedge clk);
        was_reset = reset;
        model_edge();
        #1;
        check_eq("port_dc", pdc, e_dc);
        check_eq("port_dd", pdd, e_dd);
        check_eq("nmi_n", nmi, e_nmi);
        if (was_reset) begin
            low_len = 0;
        end else if (nmi === 1'b0) begin
            low_len++;
        end else if (low_len > 0) begin
            check_eq("nmi_width", low_len, NW);
            low_len = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_nmi_low(input int budget);
        int k;
        k = 0;
        while (nmi !== 1'b0 && k < budget) begin
            cycle();
            k++;
        end
        check_eq("nmi_wait_timeout", (k < budget), 1);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] one;
        one = 8'd1;
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return ~(one << $urandom_range(0, 7));
            2:       return ~((one << $urandom_range(0, 7)) | (one << $urandom_range(0, 7)));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; h1 = 8'hFF; h2 = 8'hFF; tha = 1'b1; thb = 1'b1;
        run(3);
        reset = 1'b0;
        run(20);

        // P1 up held, then a single-tick glitch
        h1 = 8'hFE; run(TD * 5);
        h1 = 8'hFF; run(TD * 5);
        h1 = 8'hFE; run(TD);
        h1 = 8'hFF; run(TD * 5);

        // Opposing directions and TR/TH on port $DD
        h2 = 8'hFC; run(20);
        h2 = 8'hF3; run(20);
        h2 = 8'hDF; run(20);
        tha = 1'b0; run(5);
        thb = 1'b0; run(5);
        tha = 1'b1; thb = 1'b1; h2 = 8'hFF; run(20);

        // Pause on each controller in turn
        h1 = 8'hBF; run(40);
        h1 = 8'hFF; run(20);
        h2 = 8'hBF; run(40);
        h2 = 8'hFF; run(20);

        // Both at once, then release/re-press inside the pulse
        h1 = 8'hBF; h2 = 8'hBF;
        wait_nmi_low(60);
        h1 = 8'hFF; h2 = 8'hFF; run(TD);
        h1 = 8'hBF; h2 = 8'hBF; run(40);
        h1 = 8'hFF; h2 = 8'hFF; run(24);

        // Reset during pulse with pause still held
        h1 = 8'hBF;
        wait_nmi_low(60);
        run(2);
        reset = 1'b1; run(1);
        reset = 1'b0; run(50);
        h1 = 8'hFF; run(24);

        // Random stimulus
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 2));
                reset = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) h1 = 8'hBF & rand_byte(); else h1 = rand_byte();
            if ($urandom_range(0, 3) == 0) h2 = 8'hBF & rand_byte(); else h2 = rand_byte();
            tha = 1'($urandom);
            thb = 1'($urandom);
            run(TD * $urandom_range(1, 5) + $urandom_range(0, TD - 1));
        end
        h1 = 8'hFF; h2 = 8'hFF;
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
